collision_matrix: RTL and testbench

COLLISION_MATRIX -- requirements
Module: collision_matrix

---
 rtl/collision_pkg.sv | 15 +
 rtl/pair_detector.sv | 69 ++++++
 rtl/collision_matrix.sv | 60 ++++++
 tb/tb_collision_matrix.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared constants and pair-numbering helpers for the collision matrix.
package collision_pkg;

  localparam logic [7:0] MAX_HIT_FRAME_COUNT = 8'd255;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Row-major index of unordered pair (i,j), i<j, among n objects.
  function automatic int pair_index(input int i, input int j, input int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/pair_detector.sv
// Overlap, first-hit-in-frame pulse and frame summary for one object pair.
// Sticky accumulation exists only when COLLISION_MATRIX_STICKY_EN is defined.
module pair_detector #(
  parameter bit ENABLE = 1'b1
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof_i,
  input  logic hit_a_i,
  input  logic hit_b_i,
  input  logic clear_sticky_i,
  output logic collision_o,
  output logic pulse_o,
  output logic flag_o,
  output logic frame_hit_o,
  output logic sticky_o
);

  logic overlap;
  logic collision_q, pulse_q, flag_q, frame_hit_q;
  logic pulse_d, flag_d, frame_hit_d;

  assign overlap = ENABLE & hit_a_i & hit_b_i;

  // Overlap sampled on a start-of-frame cycle belongs to the new frame.
  always_comb begin
    flag_d      = sof_i ? overlap : (flag_q | overlap);
    pulse_d     = overlap & (sof_i | ~flag_q);
    frame_hit_d = sof_i ? flag_q : frame_hit_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      collision_q <= 1'b0;
      pulse_q     <= 1'b0;
      flag_q      <= 1'b0;
      frame_hit_q <= 1'b0;
    end else begin
      collision_q <= overlap;
      pulse_q     <= pulse_d;
      flag_q      <= flag_d;
      frame_hit_q <= frame_hit_d;
    end
  end

  assign collision_o = collision_q;
  assign pulse_o     = pulse_q;
  assign flag_o      = flag_q;
  assign frame_hit_o = frame_hit_q;

`ifdef COLLISION_MATRIX_STICKY_EN
  logic sticky_q, sticky_d;

  // Clear has priority over a same-cycle overlap.
  assign sticky_d = clear_sticky_i ? 1'b0 : (sticky_q | overlap);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) sticky_q <= 1'b0;
    else         sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;
`else
  logic unused_clear;
  assign unused_clear = clear_sticky_i;
  assign sticky_o     = 1'b0;
`endif

endmodule

// File: rtl/collision_matrix.sv
// Pairwise per-pixel collision detector with per-frame summary and hit counter.
// Optional sticky accumulation: define COLLISION_MATRIX_STICKY_EN.
module collision_matrix
  import collision_pkg::*;
#(
  parameter int NUMBER_OF_OBJECTS = 5,
  localparam int NUMBER_OF_PAIRS = num_pairs(NUMBER_OF_OBJECTS),
  parameter logic [NUMBER_OF_PAIRS-1:0] PAIR_MASK = '1
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic [NUMBER_OF_OBJECTS-1:0] hit_request,
  input  logic                         clear_sticky,
  output logic [NUMBER_OF_PAIRS-1:0]   collision,
  output logic [NUMBER_OF_PAIRS-1:0]   HitPulse,
  output logic [NUMBER_OF_PAIRS-1:0]   frame_hits,
  output logic [7:0]                   hit_frame_count,
  output logic [NUMBER_OF_PAIRS-1:0]   sticky_hits
);

  logic [NUMBER_OF_PAIRS-1:0] frame_flag;
  logic [7:0]                 count_q, count_d;

  for (genvar i = 0; i < NUMBER_OF_OBJECTS - 1; i++) begin : g_row
    for (genvar j = i + 1; j < NUMBER_OF_OBJECTS; j++) begin : g_col
      localparam int P = pair_index(i, j, NUMBER_OF_OBJECTS);
      pair_detector #(
        .ENABLE (PAIR_MASK[P])
      ) u_pair (
        .clk            (clk),
        .resetN         (resetN),
        .sof_i          (startOfFrame),
        .hit_a_i        (hit_request[i]),
        .hit_b_i        (hit_request[j]),
        .clear_sticky_i (clear_sticky),
        .collision_o    (collision[P]),
        .pulse_o        (HitPulse[P]),
        .flag_o         (frame_flag[P]),
        .frame_hit_o    (frame_hits[P]),
        .sticky_o       (sticky_hits[P])
      );
    end
  end

  // Counts frames that closed with at one or more overlaps; saturates.
  always_comb begin
    count_d = count_q;
    if (startOfFrame && (|frame_flag) && (count_q != MAX_HIT_FRAME_COUNT))
      count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) count_q <= 8'd0;
    else         count_q <= count_d;
  end

  assign hit_frame_count = count_q;

endmodule

// File: tb/tb_collision_matrix.sv
// Scoreboard bench: driver queues hand-computed expectations, monitor checks every cycle.
module tb_collision_matrix;

  localparam logic [9:0] M4 = 10'h010;

  logic       clk, resetN, sof, clr;
  logic [4:0] hit;
  logic [9:0] col, pul, fh, st, m_col, m_pul, m_fh, m_st;
  logic [7:0] cnt, m_cnt;

  typedef struct {
    logic [9:0] col, pul, fh, st;
    logic [7:0] cnt, mcnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  collision_matrix #(.NUMBER_OF_OBJECTS(5)) u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .hit_request(hit),
    .clear_sticky(clr), .collision(col), .HitPulse(pul), .frame_hits(fh),
    .hit_frame_count(cnt), .sticky_hits(st));

  collision_matrix #(.NUMBER_OF_OBJECTS(5), .PAIR_MASK(10'h3EF)) u_msk (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .hit_request(hit),
    .clear_sticky(clr), .collision(m_col), .HitPulse(m_pul), .frame_hits(m_fh),
    .hit_frame_count(m_cnt), .sticky_hits(m_st));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] sticky_exp(input logic [9:0] v);
`ifdef COLLISION_MATRIX_STICKY_EN
    return v;
`else
    return 10'h000 & v;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("collision",   col,           e.col);
      chk("HitPulse",    pul,           e.pul);
      chk("frame_hits",  fh,            e.fh);
      chk("count",       {2'b0, cnt},   {2'b0, e.cnt});
      chk("sticky",      st,            e.st);
      chk("m_collision", m_col,         e.col & ~M4);
      chk("m_HitPulse",  m_pul,         e.pul & ~M4);
      chk("m_frame_hits", m_fh,         e.fh & ~M4);
      chk("m_count",     {2'b0, m_cnt}, {2'b0, e.mcnt});
      chk("m_sticky",    m_st,          e.st & ~M4);
    end
  end

  task automatic step(input logic [4:0] h, input logic s, input logic c,
                      input logic [9:0] ecol, input logic [9:0] epul, input logic [9:0] efh,
                      input logic [7:0] ecnt, input logic [7:0] emcnt, input logic [9:0] est);
    exp_t e;
    @(negedge clk);
    hit = h; sof = s; clr = c;
    e.col = ecol; e.pul = epul; e.fh = efh; e.cnt = ecnt; e.mcnt = emcnt;
    e.st = sticky_exp(est);
    q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_col"}, col, 10'h0);
    chk({tag, "_pulse"}, pul, 10'h0);
    chk({tag, "_fh"}, fh, 10'h0);
    chk({tag, "_cnt"}, {2'b0, cnt}, 10'h0);
    chk({tag, "_sticky"}, st, 10'h0);
    chk({tag, "_m_fh"}, m_fh, 10'h0);
    chk({tag, "_m_cnt"}, {2'b0, m_cnt}, 10'h0);
  endtask

  initial begin
    logic [7:0] ec, emc;
    logic [9:0] efh;
    resetN = 1'b0; sof = 1'b0; clr = 1'b0; hit = 5'b0;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Held overlap of objects 0,1: one pulse, then no re-pulse in the same frame.
    for (int k = 0; k < 10; k++)
      step(5'b00011, 0, 0, 10'h001, (k == 0) ? 10'h001 : 10'h000, 10'h0, 0, 0, 10'h001);
    step(5'b00000, 0, 0, 10'h000, 10'h000, 10'h000, 0, 0, 10'h001);
    step(5'b00011, 0, 0, 10'h001, 10'h000, 10'h000, 0, 0, 10'h001);
    step(5'b00011, 0, 0, 10'h001, 10'h000, 10'h000, 0, 0, 10'h001);
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h001, 1, 1, 10'h001);
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h000, 1, 1, 10'h001);
    // Objects 3,4 -> pair 9.
    step(5'b11000, 0, 0, 10'h200, 10'h200, 10'h000, 1, 1, 10'h201);
    step(5'b00000, 0, 0, 10'h000, 10'h000, 10'h000, 1, 1, 10'h201);
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h200, 2, 2, 10'h201);
    // Overlap on the start-of-frame cycle belongs to the new frame.
    step(5'b00011, 1, 0, 10'h001, 10'h001, 10'h000, 2, 2, 10'h201);
    step(5'b00111, 0, 0, 10'h013, 10'h012, 10'h000, 2, 2, 10'h213);
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h013, 3, 3, 10'h213);
    // Pair 4 only: masked instance sees nothing.
    step(5'b00110, 0, 0, 10'h010, 10'h010, 10'h013, 3, 3, 10'h213);
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h010, 4, 3, 10'h213);
    step(5'b00110, 0, 1, 10'h010, 10'h010, 10'h010, 4, 3, 10'h000);
    step(5'b00000, 0, 0, 10'h000, 10'h000, 10'h010, 4, 3, 10'h000);
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h010, 5, 3, 10'h000);

    // 300 frames with an overlap each: counter must saturate at 255.
    ec = 8'd5; emc = 8'd3; efh = 10'h010;
    for (int k = 0; k < 300; k++) begin
      step(5'b00011, 0, 0, 10'h001, 10'h001, efh, ec, emc, 10'h001);
      if (ec != 8'd255) ec = ec + 8'd1;
      if (emc != 8'd255) emc = emc + 8'd1;
      efh = 10'h001;
      step(5'b00000, 1, 0, 10'h000, 10'h000, efh, ec, emc, 10'h001);
    end

    // Reset in the middle of a frame discards the partial-frame flags.
    step(5'b11000, 0, 0, 10'h200, 10'h200, 10'h001, 255, 255, 10'h201);
    @(negedge clk);
    resetN = 1'b0; hit = 5'b11111;
    #1 chk_zero("midreset");
    @(negedge clk);
    hit = 5'b0; resetN = 1'b1;
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h000, 0, 0, 10'h000);
    step(5'b00011, 0, 0, 10'h001, 10'h001, 10'h000, 0, 0, 10'h001);
    step(5'b00000, 1, 0, 10'h000, 10'h000, 10'h001, 1, 1, 10'h001);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
